ex_mem: RTL and testbench
=========================

# ex_mem

Pipeline register between the execute stage and the memory stage. It captures the EX result bundle: GPR write, HI/LO write, and the partial product of two-cycle multiply-accumulate. It presents the bundle to MEM one cycle later and feeds the accumulate state back to EX. It honours stall and flush requests from the pipeline controller. It also counts the bubbles it inserts, for performance monitoring.

## Interface
- No parameters. Widths come from the shared defines: `RegBus` = 32, `RegAddrBus` = 5, `DoubleRegBus` = 64.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_ex  in  1  controller holds the EX stage this cycle
- stall_mem  in  1  controller holds the MEM stage this cycle
- flush  in  1  exception/redirect; kill the in-flight bundle
- ex_wd  in  5  GPR destination from EX
- ex_wreg  in  1  GPR write enable from EX
- ex_wdata  in  32  GPR write data from EX
- ex_hi, ex_lo  in  32 each  HI/LO values from EX
- ex_whilo  in  1  HI/LO write enable from EX
- ex_hilo_temp  in  64  first-cycle MADD/MSUB product from EX
- ex_cnt  in  2  EX accumulate cycle index (0 or 1)
- mem_wd  out  5  registered GPR destination
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  32  registered GPR write data
- mem_hi, mem_lo  out  32 each  registered HI/LO values
- mem_whilo  out  1  registered HI/LO write enable
- hilo_temp_o  out  64  held partial product back to EX
- cnt_o  out  2  held accumulate index back to EX
- bubble_cnt  out  16  saturating count of inserted bubbles

## Operation
- All state updates on posedge clk. The priority per cycle is: rst > flush > bubble > advance > hold.
- **rst:** all outputs go to 0, including hilo_temp_o, cnt_o and bubble_cnt.
- **flush:** all mem_* outputs, hilo_temp_o and cnt_o go to 0. bubble_cnt is unchanged. Flush overrides any stall.
- **Bubble** (stall_ex=1, stall_mem=0):
  - mem_wreg=0, mem_whilo=0, and mem_wd/mem_wdata/mem_hi/mem_lo go to 0.
  - hilo_temp_o is loaded with ex_hilo_temp and cnt_o with ex_cnt. This preserves the accumulate state while EX re-executes.
  - bubble_cnt increments by 1 and saturates at 16'hFFFF.
- **Advance** (stall_ex=0):
  - All mem_* outputs load the corresponding ex_* inputs.
  - hilo_temp_o and cnt_o go to 0, because the accumulate has completed or was never started.
- **Hold** (stall_ex=1, stall_mem=1): every register keeps its value.
- stall_ex=0 with stall_mem=1 is illegal from the controller. The block treats it as Hold. The bench flags it with an assertion.
- No arithmetic is performed on the data path. The only arithmetic is the bubble_cnt saturating increment (16-bit, no wrap).

## Timing
- Latency: 1 cycle from ex_* inputs to mem_* outputs on advance.
- hilo_temp_o/cnt_o are valid in the cycle after a bubble, which is the cycle EX performs accumulate step 2.
- Outputs are purely registered, with no combinational path from input to output.
- Reset takes effect at the first clock edge with rst=1. Reset asserted mid-accumulate discards hilo_temp_o and cnt_o.
- When flush and a bubble occur together, flush wins and bubble_cnt does not increment.
- bubble_cnt at 16'hFFFF stays at 16'hFFFF on further bubbles.

## Structure
- Width macros (`RegBus`, `RegAddrBus`, `DoubleRegBus`) and `WriteEnable`/`WriteDisable`/`ZeroWord`/`RstEnable` come from the shared defines file. No new constants are needed.
- Split into one sub-module, `sat_counter16`: a saturating incrementer with synchronous clear, used for bubble_cnt and reusable by other stages.
- Everything else is a single clocked always block in `ex_mem`.

## Test plan
- **Reset:** with arbitrary inputs, hold rst=1 for 2 cycles → all outputs 0, bubble_cnt=0.
- **Advance:** ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB → next cycle mem_* outputs match those values, cnt_o=0, hilo_temp_o=0.
- **MADD two-cycle:**
  - Cycle 1: stall_ex=1, stall_mem=0, ex_hilo_temp=64'h0000_0001_0000_0002, ex_cnt=1 → mem_wreg=0, mem_whilo=0, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt+1.
  - Cycle 2: stall_ex=0 → mem_* loaded, cnt_o=0.
- **Hold:** load mem_wdata=32'hDEAD_BEEF, then apply stall_ex=stall_mem=1 for 3 cycles → all outputs unchanged, bubble_cnt unchanged.
- **Flush priority:** flush=1 together with stall_ex=1, stall_mem=0 and mem_wreg previously 1 → all mem_* 0, cnt_o=0, bubble_cnt unchanged.
- **Saturation:** force 65,537 bubbles → bubble_cnt stays at 16'hFFFF. A subsequent rst → 0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, write-enable constants and per-cycle action decode for the EX/MEM register
package ex_mem_pkg;
  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  typedef enum logic [2:0] {ACT_RST, ACT_FLUSH, ACT_BUBBLE, ACT_ADVANCE, ACT_HOLD} act_e;
  // Priority rst > flush > bubble > advance > hold; stall_ex=0 with stall_mem=1 falls through to hold.
  function automatic act_e pick_act(input logic rst, input logic flush, input logic stall_ex, input logic stall_mem);
    return rst == RstEnable ? ACT_RST :
           flush            ? ACT_FLUSH :
           stall_ex & ~stall_mem  ? ACT_BUBBLE :
           ~stall_ex & ~stall_mem ? ACT_ADVANCE : ACT_HOLD;
  endfunction
endpackage

// File: rtl/ex_mem_sat_counter16.sv
// sat_counter16: 16-bit incrementer that sticks at all-ones, with synchronous clear
// Ports: clk clock; clr sync clear (wins over inc); inc count enable; count current value.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with stall/flush handling, MADD/MSUB accumulate feedback and bubble counting
// Ports: clk, rst (sync, active-high); stall_ex/stall_mem/flush from the controller;
//   ex_* result bundle in; mem_* registered bundle out; hilo_temp_o/cnt_o accumulate state back to EX;
//   bubble_cnt saturating count of inserted bubbles.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_ex,
  input  logic                    stall_mem,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] ex_hilo_temp,
  input  logic [1:0]              ex_cnt,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic [DoubleRegBus-1:0] hilo_temp_o,
  output logic [1:0]              cnt_o,
  output logic [15:0]             bubble_cnt
);
  act_e act;
  always_comb act = pick_act(rst, flush, stall_ex, stall_mem);
  sat_counter16 u_bubble_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (act == ACT_BUBBLE),
    .count (bubble_cnt)
  );
  // rst, flush and bubble all empty the MEM slot; only a bubble keeps the accumulate state for EX step 2.
  always_ff @(posedge clk)
    if (act == ACT_ADVANCE) begin
      mem_wd      <= ex_wd;
      mem_wreg    <= ex_wreg;
      mem_wdata   <= ex_wdata;
      mem_hi      <= ex_hi;
      mem_lo      <= ex_lo;
      mem_whilo   <= ex_whilo;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (act != ACT_HOLD) begin
      mem_wd      <= '0;
      mem_wreg    <= WriteDisable;
      mem_wdata   <= ZeroWord;
      mem_hi      <= ZeroWord;
      mem_lo      <= ZeroWord;
      mem_whilo   <= WriteDisable;
      hilo_temp_o <= act == ACT_BUBBLE ? ex_hilo_temp : '0;
      cnt_o       <= act == ACT_BUBBLE ? ex_cnt : 2'd0;
    end
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: scoreboard bench for ex_mem with directed and random stimulus against a rule-level model
module tb_ex_mem;
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] ht;
    logic [1:0]  cnt;
    logic [15:0] bc;
  } obs_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic rst, stall_ex, stall_mem, flush, ex_wreg, ex_whilo, mem_wreg, mem_whilo;
  logic [4:0] ex_wd, mem_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, mem_wdata, mem_hi, mem_lo;
  logic [63:0] ex_hilo_temp, hilo_temp_o;
  logic [1:0] ex_cnt, cnt_o;
  logic [15:0] bubble_cnt;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
  );

  obs_t obs;
  assign obs = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o, bubble_cnt};

  obs_t m;
  obs_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk)
    assert (rst || flush || stall_ex || !stall_mem)
      else $error("FAIL illegal_stall: got stall_ex=0 stall_mem=1, required never");

  initial forever begin
    obs_t e;
    string n;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h (wd wreg wdata hi lo whilo hilo_temp cnt bubble_cnt)", n, obs, e);
      end
    end
  end

  task automatic apply(input string nm);
    logic [15:0] bc;
    bc = m.bc;
    if (rst) m = '0;
    else if (flush) begin
      m = '0;
      m.bc = bc;
    end else if (stall_ex && !stall_mem) begin
      m = '0;
      m.ht = ex_hilo_temp;
      m.cnt = ex_cnt;
      m.bc = bc == 16'hFFFF ? bc : bc + 16'd1;
    end else if (!stall_ex && !stall_mem) begin
      m = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo, whilo: ex_whilo,
            ht: 64'd0, cnt: 2'd0, bc: bc};
    end
    exp_q.push_back(m);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic rand_ex();
    ex_wd = 5'($urandom);
    ex_wreg = 1'($urandom);
    ex_wdata = $urandom;
    ex_hi = $urandom;
    ex_lo = $urandom;
    ex_whilo = 1'($urandom);
    ex_hilo_temp = {$urandom, $urandom};
    ex_cnt = 2'($urandom_range(1));
  endtask

  task automatic ctl(input logic r, input logic f, input logic sx, input logic sm);
    rst = r; flush = f; stall_ex = sx; stall_mem = sm;
  endtask

  initial begin
    m = '0;
    rand_ex();
    ctl(1, 1, 1, 0);
    apply("reset_0");
    rand_ex();
    apply("reset_1");
    ctl(0, 0, 0, 0);
    ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'h1234_5678; ex_whilo = 1; ex_hi = 32'hA; ex_lo = 32'hB;
    ex_hilo_temp = 64'hFFFF_0000_FFFF_0000; ex_cnt = 2'd1;
    apply("advance");
    ctl(0, 0, 1, 0);
    ex_hilo_temp = 64'h0000_0001_0000_0002; ex_cnt = 2'd1;
    apply("madd_bubble");
    ctl(0, 0, 0, 0);
    ex_wd = 5'd7; ex_wdata = 32'h0BAD_F00D; ex_hi = 32'h1; ex_lo = 32'h2; ex_cnt = 2'd0;
    apply("madd_step2");
    ex_wdata = 32'hDEAD_BEEF;
    apply("hold_load");
    ctl(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      apply("hold");
    end
    ctl(0, 0, 0, 0);
    rand_ex();
    ex_wreg = 1;
    apply("flush_pre");
    ctl(0, 1, 1, 0);
    rand_ex();
    apply("flush_prio");
    for (int i = 0; i < 800; i++) begin
      int sel;
      sel = $urandom_range(99);
      rand_ex();
      ctl($urandom_range(99) < 3, $urandom_range(99) < 8, sel < 50, sel >= 80);
      if (!stall_ex) stall_mem = 0;
      apply("random");
    end
    ctl(1, 0, 0, 0);
    apply("sat_reset");
    ctl(0, 0, 1, 0);
    for (int i = 0; i < 65537; i++) begin
      rand_ex();
      apply("saturate");
    end
    ctl(0, 1, 1, 0);
    apply("sat_flush");
    ctl(0, 0, 1, 1);
    apply("sat_hold");
    ctl(1, 0, 1, 0);
    apply("sat_clear");
    ctl(0, 0, 0, 0);
    apply("post_clear");
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
